fifo_rd_gearbox: RTL and testbench

- Sits directly downstream of the team's N-to-M register FIFO.
- Pulls up to M words per cycle through the FIFO's count-based read port (words_avail / rd_en).
- Packs those words into fixed K-word output beats with a valid/ready handshake.
- A flush request closes a partial beat, which is then emitted with a word count and a last flag.

---
 rtl/fifo_rd_gearbox.sv | 113 +++++++++++
 tb/tb_fifo_rd_gearbox.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_gearbox.sv
// fifo_rd_gearbox: pulls up to M words per cycle from a count-based FIFO
// read port and packs them into K-word output beats; flush closes a beat.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   fifo_data           M head words from the FIFO, lane 0 oldest
//   fifo_words_avail    words valid on fifo_data this cycle
//   fifo_rd_en          words consumed this cycle (combinational)
//   flush               one-cycle pulse, ends the current packet
//   out_data/out_cnt    beat words (word 0 oldest) and valid count
//   out_last            beat closes a flushed packet
//   out_valid/out_ready beat handshake
module fifo_rd_gearbox #(
    parameter int DATA_WIDTH = 8,
    parameter int M          = 2,
    parameter int K          = 4,
    parameter int CW         = $clog2(K + 1),
    parameter int FW         = $clog2(M + 1)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [M-1:0][DATA_WIDTH-1:0] fifo_data,
    input  logic [FW-1:0]                fifo_words_avail,
    output logic [FW-1:0]                fifo_rd_en,
    input  logic                         flush,
    output logic [K-1:0][DATA_WIDTH-1:0] out_data,
    output logic [CW-1:0]                out_cnt,
    output logic                         out_last,
    output logic                         out_valid,
    input  logic                         out_ready
);

    // One extra bit so counts and index sums never wrap.
    localparam int SW = CW + 1;
    localparam logic [SW-1:0] K_S = SW'(K);

    logic [K-1:0][DATA_WIDTH-1:0] acc;
    logic [K-1:0][DATA_WIDTH-1:0] acc_nxt;
    logic [CW-1:0]                acc_cnt;
    logic [CW-1:0]                acc_cnt_nxt;
    logic                         flush_pending;
    logic                         flush_pending_nxt;

    logic          fire;
    logic [SW-1:0] avail_s;
    logic [SW-1:0] cnt_s;
    logic [SW-1:0] room;
    logic [SW-1:0] take;
    logic [SW-1:0] base;
    logic [SW-1:0] sum;

    always_comb begin
        avail_s   = SW'(fifo_words_avail);
        cnt_s     = SW'(acc_cnt);
        room      = K_S - cnt_s;
        out_valid = (cnt_s == K_S) || (flush_pending && cnt_s != '0);
        fire      = out_valid && out_ready;
        out_cnt   = acc_cnt;
        out_data  = acc;
        out_last  = flush_pending && out_valid;

        // Gated by rst_n so nothing is consumed while held in reset.
        take = '0;
        if (!rst_n || flush_pending) begin
            take = '0;
        end else if (fire) begin
            take = (avail_s < K_S) ? avail_s : K_S;
        end else if (!out_valid) begin
            take = (avail_s < room) ? avail_s : room;
        end
        fifo_rd_en = FW'(take);

        // A firing beat restarts packing at word 0.
        base = fire ? '0 : cnt_s;
        sum  = base + take;
        acc_cnt_nxt = CW'(sum);

        acc_nxt = acc;
        for (int i = 0; i < M; i++) begin
            for (int j = 0; j < K; j++) begin
                if (SW'(i) < take && base + SW'(i) == SW'(j)) begin
                    acc_nxt[j] = fifo_data[i];
                end
            end
        end

        // Pending clears on the closing fire, or at once if nothing
        // was buffered; repeat flushes while pending are absorbed.
        if (flush_pending) begin
            flush_pending_nxt = !(fire || cnt_s == '0);
        end else begin
            flush_pending_nxt = flush;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc           <= '0;
            acc_cnt       <= '0;
            flush_pending <= 1'b0;
        end else begin
            acc           <= acc_nxt;
            acc_cnt       <= acc_cnt_nxt;
            flush_pending <= flush_pending_nxt;
        end
    end

    a_no_overfill : assert property (
        @(posedge clk) disable iff (!rst_n) sum <= K_S);

    a_no_overread : assert property (
        @(posedge clk) disable iff (!rst_n) take <= avail_s);

endmodule

// File: tb/tb_fifo_rd_gearbox.sv
// tb_fifo_rd_gearbox: directed bench with a beat scoreboard for
// fifo_rd_gearbox at DATA_WIDTH=8, M=2, K=4.
module tb_fifo_rd_gearbox;

    localparam int DW = 8;
    localparam int M  = 2;
    localparam int K  = 4;
    localparam int CW = $clog2(K + 1);
    localparam int FW = $clog2(M + 1);

    logic                 clk;
    logic                 rst_n;
    logic [M-1:0][DW-1:0] fifo_data;
    logic [FW-1:0]        fifo_words_avail;
    logic [FW-1:0]        fifo_rd_en;
    logic                 flush;
    logic [K-1:0][DW-1:0] out_data;
    logic [CW-1:0]        out_cnt;
    logic                 out_last;
    logic                 out_valid;
    logic                 out_ready;

    typedef struct {
        logic [31:0] data;
        int          cnt;
        logic        last;
    } beat_t;

    beat_t sb[$];
    int checks;
    int failures;

    fifo_rd_gearbox #(
        .DATA_WIDTH(DW),
        .M(M),
        .K(K)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .fifo_data(fifo_data),
        .fifo_words_avail(fifo_words_avail),
        .fifo_rd_en(fifo_rd_en),
        .flush(flush),
        .out_data(out_data),
        .out_cnt(out_cnt),
        .out_last(out_last),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input int av, input logic [7:0] d0,
                       input logic [7:0] d1);
        fifo_words_avail = FW'(av);
        fifo_data        = {d1, d0};
    endtask

    task automatic push(input logic [31:0] d, input int c, input logic l);
        beat_t b;
        b.data = d;
        b.cnt  = c;
        b.last = l;
        sb.push_back(b);
    endtask

    // Inputs change only just after posedge, so a handshake seen at the
    // negedge is the one that completes at the following posedge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_beat", 32'd1, 32'd0);
            end else begin
                beat_t e;
                logic [31:0] mask;
                e = sb.pop_front();
                mask = '0;
                for (int j = 0; j < K; j++) begin
                    if (j < e.cnt) mask[j*8 +: 8] = 8'hff;
                end
                chk("sb_cnt", 32'(out_cnt), 32'(e.cnt));
                chk("sb_last", 32'(out_last), 32'(e.last));
                chk("sb_data", 32'(out_data) & mask, e.data & mask);
            end
        end
    end

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        drv(2, 8'h10, 8'h11);

        // 1: reset state, then two 2-word takes fill a beat
        #2;
        chk("rst_rd_en", 32'(fifo_rd_en), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_cnt", 32'(out_cnt), 0);
        chk("rst_last", 32'(out_last), 0);
        chk("rst_data", 32'(out_data), 0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        chk("t1_rd_en_a", 32'(fifo_rd_en), 2);
        push(32'h13121110, 4, 1'b0);
        tick();
        drv(2, 8'h12, 8'h13);
        #1;
        chk("t1_rd_en_b", 32'(fifo_rd_en), 2);
        tick();
        out_ready = 1'b0;
        drv(2, 8'h20, 8'h21);
        #1;
        chk("t1_valid", 32'(out_valid), 1);
        chk("t1_data", 32'(out_data), 32'h13121110);
        chk("t1_cnt", 32'(out_cnt), 4);
        chk("t1_last", 32'(out_last), 0);

        // 2: five stalled cycles, then fire with a same-cycle take
        for (int n = 0; n < 5; n++) begin
            chk("t2_stall_rd_en", 32'(fifo_rd_en), 0);
            chk("t2_stall_data", 32'(out_data), 32'h13121110);
            tick();
            #1;
        end
        out_ready = 1'b1;
        #1;
        chk("t2_fire_rd_en", 32'(fifo_rd_en), 2);
        tick();
        drv(1, 8'h22, 8'hee);
        #1;
        chk("t2_cnt_after", 32'(out_cnt), 2);
        chk("t2_valid_after", 32'(out_valid), 0);

        // 3: partial take leaves the FIFO's second word in place
        chk("t3_rd_en_1", 32'(fifo_rd_en), 1);
        tick();
        drv(2, 8'h23, 8'h24);
        #1;
        chk("t3_cnt3", 32'(out_cnt), 3);
        chk("t3_rd_en_partial", 32'(fifo_rd_en), 1);
        push(32'h23222120, 4, 1'b0);
        tick();
        drv(1, 8'haa, 8'hee);
        #1;
        chk("t3_cnt4", 32'(out_cnt), 4);
        chk("t3_fire_rd_en", 32'(fifo_rd_en), 1);

        // 4: flush a 1-word beat, stall it, then release
        tick();
        flush = 1'b1;
        drv(0, 8'h00, 8'h00);
        #1;
        chk("t4_cnt1", 32'(out_cnt), 1);
        chk("t4_flush_rd_en", 32'(fifo_rd_en), 0);
        push(32'h000000aa, 1, 1'b1);
        tick();
        flush     = 1'b0;
        out_ready = 1'b0;
        drv(2, 8'h30, 8'h31);
        #1;
        chk("t4_valid", 32'(out_valid), 1);
        chk("t4_cnt", 32'(out_cnt), 1);
        chk("t4_last", 32'(out_last), 1);
        for (int n = 0; n < 3; n++) begin
            chk("t4_hold_rd_en", 32'(fifo_rd_en), 0);
            chk("t4_hold_data0", 32'(out_data[0]), 32'haa);
            tick();
            #1;
        end
        out_ready = 1'b1;
        #1;
        chk("t4_fire_rd_en", 32'(fifo_rd_en), 0);
        chk("t4_fire_last", 32'(out_last), 1);
        tick();
        #1;
        chk("t4_post_valid", 32'(out_valid), 0);
        chk("t4_post_last", 32'(out_last), 0);
        chk("t4_resume_rd_en", 32'(fifo_rd_en), 2);
        drv(0, 8'h00, 8'h00);

        // 5: flush with empty acc, then flush with a 2-word take
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drv(2, 8'h40, 8'h41);
        #1;
        chk("t5_empty_valid", 32'(out_valid), 0);
        chk("t5_pending_rd_en", 32'(fifo_rd_en), 0);
        tick();
        flush     = 1'b1;
        out_ready = 1'b0;
        #1;
        chk("t5_resume_rd_en", 32'(fifo_rd_en), 2);
        push(32'h00004140, 2, 1'b1);
        tick();
        flush = 1'b0;
        drv(0, 8'h00, 8'h00);
        #1;
        chk("t5_valid", 32'(out_valid), 1);
        chk("t5_cnt", 32'(out_cnt), 2);
        chk("t5_last", 32'(out_last), 1);
        out_ready = 1'b1;
        tick();
        #1;
        chk("t5_post_valid", 32'(out_valid), 0);

        // flush of a full beat already stalled
        out_ready = 1'b0;
        drv(2, 8'h50, 8'h51);
        tick();
        drv(2, 8'h52, 8'h53);
        tick();
        drv(0, 8'h00, 8'h00);
        flush = 1'b1;
        push(32'h53525150, 4, 1'b1);
        tick();
        flush = 1'b0;
        #1;
        chk("full_flush_cnt", 32'(out_cnt), 4);
        chk("full_flush_last", 32'(out_last), 1);
        out_ready = 1'b1;
        tick();

        // 6: async reset mid-beat discards partial data
        drv(2, 8'h60, 8'h61);
        tick();
        drv(1, 8'h62, 8'hee);
        tick();
        drv(2, 8'h63, 8'h64);
        #1;
        chk("t6_cnt3", 32'(out_cnt), 3);
        chk("t6_rd_en", 32'(fifo_rd_en), 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_async_valid", 32'(out_valid), 0);
        chk("t6_async_cnt", 32'(out_cnt), 0);
        chk("t6_async_rd_en", 32'(fifo_rd_en), 0);
        tick();
        rst_n = 1'b1;
        drv(2, 8'h70, 8'h71);
        #1;
        chk("t6_post_rd_en", 32'(fifo_rd_en), 2);
        push(32'h73727170, 4, 1'b0);
        tick();
        drv(2, 8'h72, 8'h73);
        tick();
        drv(0, 8'h00, 8'h00);
        tick();
        tick();
        tick();

        chk("sb_drained", 32'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
